// File: rtl/definitions.sv
// Shared R.O.E. datapath definitions.
// ALU op codes, execute-unit states and flag bundle.
package definitions;

  typedef enum logic [3:0] {
    ADD     = 4'b0000,
    SUB     = 4'b0001,
    SHIFTL  = 4'b0010,
    SHIFTR  = 4'b0011,
    SLB     = 4'b0100,
    BNZ     = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_XOR = 4'b0111,
    ALU_AND = 4'b1000,
    ALU_OR  = 4'b1001,
    MUL     = 4'b1010,
    ROTL    = 4'b1011
  } alu_code;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } exec_state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic branch;
    logic illegal;
  } exec_flags_t;

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done is high in the cycle whose edge retires the last bit.
module exec_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W);

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc_nx;

  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign done   = busy && (cnt == '0);
  assign prod   = acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(W - 1);
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Handshaked execute unit: single-cycle ALU ops plus iterative MUL.
// Result and flags are registered and held until consumed.
module exec_unit
  import definitions::*;
#(
  parameter int W    = 8,
  parameter int SH_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         branch_taken,
  output logic         illegal
);

  exec_state_t state, state_nx;
  logic [W-1:0] res_q;
  exec_flags_t  flg_q;

  logic accept, is_mul, mul_done;
  logic [2*W-1:0] prod;

  logic [SH_W-1:0] sh;
  logic [W:0]      sum, diff;
  logic [2*W-1:0]  rot;
  logic [W-1:0]    alu_res;
  logic            alu_c, alu_ill, br;
  exec_flags_t     alu_flg, mul_flg;

  assign in_ready  = (state == IDLE) ||
                     (state == HOLD && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == MUL);

  exec_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (prod)
  );

  assign sh   = b[SH_W-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // upper half of {a,a} shifted left is a rotated left
  assign rot  = {a, a} << sh;
  assign br   = (op == BNZ) && (a != '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    unique case (1'b1)
      op == SLB:     alu_res = {a[W-1:4], b[3:0]};
      op == ADD: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
      end
      op == SUB: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
      end
      op == SHIFTL:  alu_res = a << sh;
      op == SHIFTR:  alu_res = a >> sh;
      op == ROTL:    alu_res = rot[2*W-1:W];
      op == BNZ:     alu_res = a;
      op == ALU_SLT: alu_res = {{(W-1){1'b0}},
                       $signed(a) < $signed(b)};
      op == ALU_XOR: alu_res = a ^ b;
      op == ALU_AND: alu_res = a & b;
      op == ALU_OR:  alu_res = a | b;
      op == MUL:     alu_res = '0;
      default:       alu_ill = 1'b1;
    endcase
  end

  assign alu_flg = '{zero: alu_res == '0, carry: alu_c,
                     branch: br, illegal: alu_ill};
  assign mul_flg = '{zero: prod[W-1:0] == '0,
                     carry: |prod[2*W-1:W],
                     branch: 1'b0, illegal: 1'b0};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = is_mul ? CALC : HOLD;
      CALC: if (mul_done) state_nx = HOLD;
      HOLD: if (out_ready)
              state_nx = !accept ? IDLE :
                         is_mul  ? CALC : HOLD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      state <= state_nx;
      if (accept && !is_mul) begin
        res_q <= alu_res;
        flg_q <= alu_flg;
      end else if (mul_done) begin
        res_q <= prod[W-1:0];
        flg_q <= mul_flg;
      end
    end
  end

  assign result       = res_q;
  assign zero         = flg_q.zero;
  assign carry        = flg_q.carry;
  assign branch_taken = flg_q.branch;
  assign illegal      = flg_q.illegal;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: vector table, random ops
// against an arithmetic model, stall and mid-MUL reset sequences.
module tb_exec_unit;
  import definitions::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] op;
  logic [7:0] a, b, result;
  logic       out_valid, out_ready;
  logic       zero, carry, branch_taken, illegal;

  logic        v2, r2, ov2, z2, c2, bt2, il2;
  logic [3:0]  op2;
  logic [15:0] a2, b2, res2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  exec_unit #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  exec_unit #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(r2),
    .op(op2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(1'b1),
    .result(res2), .zero(z2), .carry(c2),
    .branch_taken(bt2), .illegal(il2)
  );

  typedef struct {
    logic [7:0] res;
    logic z, c, br, il;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, res;
    logic z, c, br, il;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string n,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [7:0] x,
                                 input logic [7:0] y);
    exp_t e;
    int xi, yi, s, r, sx, sy;
    xi = int'(x);
    yi = int'(y);
    s  = yi % 8;
    sx = (xi > 127) ? xi - 256 : xi;
    sy = (yi > 127) ? yi - 256 : yi;
    r  = 0;
    e  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    case (o)
      ADD:     begin r = xi + yi; e.c = (r > 255); end
      SUB:     begin r = xi - yi; e.c = (xi < yi); end
      SHIFTL:  r = xi << s;
      SHIFTR:  r = xi >> s;
      ROTL:    r = (xi << s) | (xi >> (8 - s));
      SLB:     r = (xi / 16) * 16 + (yi % 16);
      BNZ:     begin r = xi; e.br = (xi != 0); end
      ALU_SLT: r = (sx < sy) ? 1 : 0;
      ALU_XOR: r = xi ^ yi;
      ALU_AND: r = xi & yi;
      ALU_OR:  r = xi | yi;
      MUL:     begin r = xi * yi; e.c = (r > 255); end
      default: e.il = 1'b1;
    endcase
    e.res = 8'(r & 255);
    e.z   = (e.res == 8'h00);
    return e;
  endfunction

  // issue one op with out_ready as currently set; lat = edges
  // from the accept edge up to the one that raises out_valid
  task automatic do_op(input logic [3:0] o,
                       input logic [7:0] x,
                       input logic [7:0] y,
                       output int lat);
    int g;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    exp_t e;
    logic [3:0] ro;
    logic [7:0] rx, ry;

    vt[0]  = '{ADD,     8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{SUB,     8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{ALU_SLT, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{MUL,     8'h10, 8'h11, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{MUL,     8'h07, 8'h09, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{BNZ,     8'h00, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{BNZ,     8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{4'hF,    8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{SLB,     8'hAB, 8'hCD, 8'hAD, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{SHIFTR,  8'h80, 8'h0B, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{SHIFTL,  8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{ROTL,    8'h81, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{ALU_XOR, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{ALU_AND, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{ALU_OR,  8'h30, 8'h03, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{ADD,     8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[16] = '{SUB,     8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[17] = '{ALU_SLT, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'h0; a = 8'h00; b = 8'h00;
    v2 = 1'b0; op2 = 4'h0; a2 = 16'h0; b2 = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_result", {8'h0, result}, 16'h0);
    chk("rst_out_valid", {15'h0, out_valid}, 16'h0);
    chk("rst_in_ready", {15'h0, in_ready}, 16'h1);
    chk("rst_flags", {12'h0, zero, carry, branch_taken, illegal},
        16'h0);

    for (int i = 0; i < 18; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, lat);
      chk($sformatf("vec%0d_res", i), {8'h0, result},
          {8'h0, vt[i].res});
      chk($sformatf("vec%0d_flags", i),
          {12'h0, zero, carry, branch_taken, illegal},
          {12'h0, vt[i].z, vt[i].c, vt[i].br, vt[i].il});
      chk($sformatf("vec%0d_lat", i), 16'(lat),
          (vt[i].op == MUL) ? 16'd9 : 16'd1);
    end

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = 8'($urandom);
      ry = 8'($urandom);
      e  = model(ro, rx, ry);
      do_op(ro, rx, ry, lat);
      chk($sformatf("rnd%0d_op%0h_res", i, ro), {8'h0, result},
          {8'h0, e.res});
      chk($sformatf("rnd%0d_flags", i),
          {12'h0, zero, carry, branch_taken, illegal},
          {12'h0, e.z, e.c, e.br, e.il});
      chk($sformatf("rnd%0d_lat", i), 16'(lat),
          (ro == MUL) ? 16'd9 : 16'd1);
    end

    // consumer stall, then a queued ADD with no bubble
    @(posedge clk);
    @(negedge clk) out_ready = 1'b0;
    do_op(ADD, 8'h01, 8'h02, lat);
    chk("stall_first", {8'h0, result}, 16'h3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op = ADD; a = 8'h04; b = 8'h05; in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_res", k), {8'h0, result}, 16'h3);
      chk($sformatf("stall%0d_vld", k), {15'h0, out_valid}, 16'h1);
      chk($sformatf("stall%0d_rdy", k), {15'h0, in_ready}, 16'h0);
    end
    @(negedge clk) out_ready = 1'b1;
    #1 chk("stall_rdy_comb", {15'h0, in_ready}, 16'h1);
    @(posedge clk);
    #1;
    chk("nobubble_vld", {15'h0, out_valid}, 16'h1);
    chk("nobubble_res", {8'h0, result}, 16'h9);
    in_valid = 1'b0;

    // reset in the middle of a MUL
    @(posedge clk);
    @(negedge clk);
    op = MUL; a = 8'h07; b = 8'h09; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_res", {8'h0, result}, 16'h0);
    chk("midrst_vld", {15'h0, out_valid}, 16'h0);
    chk("midrst_rdy", {15'h0, in_ready}, 16'h1);
    chk("midrst_flags", {12'h0, zero, carry, branch_taken, illegal},
        16'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    do_op(ADD, 8'h01, 8'h01, lat);
    chk("postrst_res", {8'h0, result}, 16'h2);
    chk("postrst_lat", 16'(lat), 16'd1);
    repeat (12) @(posedge clk);
    #1 chk("postrst_idle", {15'h0, out_valid}, 16'h0);

    // 16-bit instance rotate
    @(negedge clk);
    op2 = ROTL; a2 = 16'h8001; b2 = 16'h0004; v2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    chk("w16_rotl_vld", {15'h0, ov2}, 16'h1);
    chk("w16_rotl_res", res2, 16'h0018);
    chk("w16_rotl_flags", {12'h0, z2, c2, bt2, il2}, 16'h0);
    chk("w16_rdy", {15'h0, r2}, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, handshaked execute unit for the R.O.E. datapath, and the successor to the fixed 8-bit combinational ALU. It takes an `alu_code` operation plus two W-bit operands over a valid/ready channel. It returns a registered result with zero/carry/branch flags over a second valid/ready channel. Two new operations are added: iterative MUL and ROTL. It sits between decode/register-read and writeback, and can stall either side.

## Interface
Parameters:
- `W`, 8: operand/result width, ≥ 8
- `SH_W`, `$clog2(W)`: shift-amount width, derived and not overridden

Ports:
- `clk`, input, 1: rising-edge clock
- `rst_n`, input, 1: asynchronous, active-low reset
- `in_valid`, input, 1: request valid
- `in_ready`, output, 1: unit can accept a request this cycle
- `op`, input, 4: `alu_code`
- `a`, input, W: operand A
- `b`, input, W: operand B
- `out_valid`, output, 1: result valid
- `out_ready`, input, 1: consumer accepts the result
- `result`, output, W: registered result
- `zero`, output, 1: `result == 0`
- `carry`, output, 1: carry, borrow, or multiply overflow
- `branch_taken`, output, 1: BNZ outcome
- `illegal`, output, 1: op was an undefined code

## Operation
- A request is accepted on a rising edge with `in_valid && in_ready`. `op`, `a` and `b` are sampled at that edge.
- Operation semantics (carry = 0 unless stated):
  - SLB: `{a[W-1:4], b[3:0]}`
  - ADD: `a+b`; carry = bit W of the sum
  - SUB: `a-b`; carry = `a<b` unsigned (borrow)
  - SHIFTL: `a << b[SH_W-1:0]`
  - SHIFTR: `a >> b[SH_W-1:0]`, logical
  - ROTL: `a` rotated left by `b[SH_W-1:0]`
  - BNZ: result = `a`; `branch_taken` = `a != 0`
  - ALU_SLT: result = 1 if `$signed(a) < $signed(b)`, else 0
  - ALU_XOR / ALU_AND / ALU_OR: bitwise
  - MUL: low W bits of `a*b`, computed by shift-add one bit per cycle; carry = OR of the high W bits
- Any other code: result 0, `illegal` = 1, latency as a single-cycle op.
- `branch_taken` is 0 for every op other than BNZ.
- All outputs are registered. Result and flags hold stable while `out_valid && !out_ready`.
- States:
  - IDLE: `in_ready` = 1, `out_valid` = 0
  - CALC: MUL only; `in_ready` = 0, iteration counter runs from W-1 down to 0
  - HOLD: `out_valid` = 1; `in_ready = out_ready`
- Transitions:
  - IDLE, accepting non-MUL → HOLD
  - IDLE, accepting MUL → CALC
  - CALC, when counter = 0 → HOLD
  - HOLD, `out_ready` with a new request accepted → HOLD (non-MUL) or CALC (MUL)
  - HOLD, `out_ready` with no request → IDLE
- Reset (asynchronous, at any time including mid-MUL):
  - state = IDLE; `result` = 0, all flags = 0, `out_valid` = 0
  - any in-flight operation is discarded
  - `in_ready` = 1 the first cycle after `rst_n` rises

## Timing
- Single-cycle ops: accepted at edge k → `out_valid` = 1 after edge k.
- MUL: accepted at edge k → `out_valid` = 1 after edge k+W.
- Throughput: one non-MUL op per cycle when `out_ready` is held at 1, because HOLD→HOLD is back-to-back.
- `in_ready` has a combinational path from `out_ready` in HOLD. No other input→output combinational paths exist.
- Shift amounts ≥ W cannot occur, because only `SH_W` bits of `b` are used.

## Structure
- Add to the shared `definitions` package:
  - `alu_code` values MUL = 4'b1010 and ROTL = 4'b1011
  - `exec_state_t` enum {IDLE, CALC, HOLD}
- Sub-module `exec_mul_seq`: W-cycle shift-add multiplier with start/done signals and a 2W-bit product. It is reset by `rst_n` and cleared by `start`.
- The top level contains the FSM, the single-cycle datapath, output registers and flags.

## Test plan
- W=8, ADD a=8'hF0, b=8'h20, `out_ready`=1 → one cycle later: result 8'h10, carry 1, zero 0.
- SUB a=3, b=5 → result 8'hFE, carry 1. SLT a=8'h80, b=1 → result 1.
- MUL a=8'h10, b=8'h11 → `out_valid` after exactly 8+1 edges; result 8'h10, carry 1. MUL 7×9 → 63, carry 0.
- `out_ready`=0 for 3 cycles after a result → result and flags stable, `in_ready`=0. Raise `out_ready` with a queued ADD → new result next cycle with no bubble.
- Assert `rst_n`=0 at cycle 4 of a MUL → outputs 0 immediately, state IDLE. A following ADD 1+1 returns 2 with correct latency.
- Other cases:
  - BNZ a=0 → `branch_taken` 0, zero 1
  - BNZ a=5 → `branch_taken` 1
  - op=4'b1111 → `illegal` 1, result 0
  - W=16 ROTL a=16'h8001, b=4 → result 16'h0018
